// File: rtl/fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the instruction-fetch stage, the IF/ID register and
// the hazard unit: datapath widths, FSM state encoding, bubble encoding and
// the PC increment helper.
// ---------------------------------------------------------------------------
package fetch_unit_pkg;

  localparam int PC_W   = 16;
  localparam int INST_W = 16;

  // Fetch FSM state encoding
  localparam logic [1:0] ST_FETCH = 2'd0;  // request outstanding at PC
  localparam logic [1:0] ST_HOLD  = 2'd1;  // word captured, waiting for PCWrite
  localparam logic [1:0] ST_DRAIN = 2'd2;  // redirect queued behind in-flight request

  // Instruction word used for pipeline bubbles
  localparam logic [INST_W-1:0] NOP_ENC = 16'h0000;

  // Instructions are 2 bytes; the sum wraps modulo 2^PC_W
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(2);
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage (writer side of IF/ID). Owns the PC, issues at most
// one outstanding instruction-memory request, and presents inst / PC_Plus2.
// Stalls hold the fetched word; taken branches redirect the PC and flush IF/ID.
//
// Ports
//   clk            in   pipeline clock, rising edge
//   reset          in   asynchronous active-low reset
//   PCWrite        in   1 = IF/ID accepts this cycle, 0 = stall
//   branch_taken   in   redirect request (single-cycle pulse)
//   branch_target  in   redirect address, valid with branch_taken
//   imem_req       out  instruction memory request
//   imem_addr      out  request address (stable until imem_ready)
//   imem_rdata     in   instruction word, valid with imem_ready
//   imem_ready     in   completes the current request this cycle
//   inst           out  instruction to IF/ID
//   PC_Plus2       out  address of delivered instruction + 2
//   flush          out  clears IF/ID this cycle
// ---------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0]   RESET_PC = 16'h0000,
  parameter logic [INST_W-1:0] NOP_INST = NOP_ENC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PCWrite,
  input  logic              branch_taken,
  input  logic [PC_W-1:0]   branch_target,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              imem_ready,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   PC_Plus2,
  output logic              flush
);

  logic [1:0]        r_state;
  logic [PC_W-1:0]   r_pc;
  logic [INST_W-1:0] r_hold_inst;
  logic [PC_W-1:0]   r_redirect_pc;

  // Single incrementer shared by the PC_Plus2 output and PC next-state
  logic [PC_W-1:0]   w_pc_plus2;
  assign w_pc_plus2 = pc_inc(r_pc);

  // -------------------------------------------------------------------------
  // Outputs. While reset is held the registers already sit at their reset
  // values, but imem_ready/branch_taken may still toggle, so gate with reset.
  // The PC never moves while a request is in flight, so r_pc is also the
  // latched address in DRAIN.
  // -------------------------------------------------------------------------
  assign imem_addr = r_pc;
  assign PC_Plus2  = w_pc_plus2;
  assign imem_req  = reset && (r_state != ST_HOLD);
  assign flush     = reset && branch_taken;

  always_comb begin
    // NOTE: default first so every path assigns inst and no latch is inferred.
    inst = NOP_INST;
    if (reset && !branch_taken) begin
      case (r_state)
        ST_FETCH: if (imem_ready) inst = imem_rdata;
        ST_HOLD:  inst = r_hold_inst;
        default:  inst = NOP_INST;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State / PC update. Redirect outranks both stall and data delivery.
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_FETCH;
      r_pc          <= RESET_PC;
      r_hold_inst   <= NOP_INST;
      r_redirect_pc <= '0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (branch_taken) begin
            if (imem_ready) begin
              r_pc <= branch_target;               // fetched word discarded
            end else begin
              r_redirect_pc <= branch_target;      // keep address stable
              r_state       <= ST_DRAIN;
            end
          end else if (imem_ready) begin
            if (PCWrite) begin
              r_pc <= w_pc_plus2;
            end else begin
              r_hold_inst <= imem_rdata;
              r_state     <= ST_HOLD;
            end
          end
        end

        ST_HOLD: begin
          if (branch_taken) begin
            r_pc    <= branch_target;              // held word discarded
            r_state <= ST_FETCH;
          end else if (PCWrite) begin
            r_pc    <= w_pc_plus2;
            r_state <= ST_FETCH;
          end
        end

        ST_DRAIN: begin
          if (imem_ready) begin
            // Returned word belongs to the abandoned path; drop it
            r_pc    <= branch_taken ? branch_target : r_redirect_pc;
            r_state <= ST_FETCH;
          end else if (branch_taken) begin
            r_redirect_pc <= branch_target;        // youngest redirect wins
          end
        end

        default: r_state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. The instruction memory answers with
// addr ^ 16'hA5A5 so every delivered word identifies its fetch address.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCWrite;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ready;
  logic [15:0] inst;
  logic [15:0] PC_Plus2;
  logic        flush;

  localparam logic [15:0] NOP = 16'h0000;

  fetch_unit #(.RESET_PC(16'h0000), .NOP_INST(16'h0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .PCWrite       (PCWrite),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ready    (imem_ready),
    .inst          (inst),
    .PC_Plus2      (PC_Plus2),
    .flush         (flush)
  );

  always #5 clk = ~clk;

  // Zero-latency memory model; tolerates imem_req dropping at any time
  assign imem_rdata = imem_addr ^ 16'hA5A5;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        pw;
    logic        bt;
    logic [15:0] tgt;
    logic        rdy;
    logic        e_req;
    logic [15:0] e_addr;   // checked only when e_req=1
    logic [15:0] e_inst;
    logic [15:0] e_pp2;
    logic        e_flush;
  } vec_t;

  vec_t vecs[$];

  task automatic drive(input logic pw, input logic bt, input logic [15:0] tgt, input logic rdy);
    PCWrite       = pw;
    branch_taken  = bt;
    branch_target = tgt;
    imem_ready    = rdy;
  endtask

  task automatic check_outs(input string tag, input logic e_req, input logic [15:0] e_addr,
                            input logic [15:0] e_inst, input logic [15:0] e_pp2,
                            input logic e_flush);
    check({tag, ".req"},   16'(imem_req), 16'(e_req));
    if (e_req) check({tag, ".addr"}, imem_addr, e_addr);
    check({tag, ".inst"},  inst, e_inst);
    check({tag, ".pp2"},   PC_Plus2, e_pp2);
    check({tag, ".flush"}, 16'(flush), 16'(e_flush));
  endtask

  initial begin
    //            pw  bt  tgt       rdy  req addr      inst      pp2       flush
    // Zero-wait streaming from reset
    vecs.push_back('{1, 0, 16'h0000, 1,  1, 16'h0000, 16'hA5A5, 16'h0002, 0});
    vecs.push_back('{1, 0, 16'h0000, 1,  1, 16'h0002, 16'hA5A7, 16'h0004, 0});
    // Stall three cycles at 0004, resume at 0006
    vecs.push_back('{0, 0, 16'h0000, 1,  1, 16'h0004, 16'hA5A1, 16'h0006, 0});
    vecs.push_back('{0, 0, 16'h0000, 1,  0, 16'h0000, 16'hA5A1, 16'h0006, 0});
    vecs.push_back('{0, 0, 16'h0000, 1,  0, 16'h0000, 16'hA5A1, 16'h0006, 0});
    vecs.push_back('{1, 0, 16'h0000, 1,  0, 16'h0000, 16'hA5A1, 16'h0006, 0});
    vecs.push_back('{1, 0, 16'h0000, 1,  1, 16'h0006, 16'hA5A3, 16'h0008, 0});
    // Wait states at 0008, branch to 0080 in cycle 2 -> DRAIN
    vecs.push_back('{1, 0, 16'h0000, 0,  1, 16'h0008, NOP,      16'h000A, 0});
    vecs.push_back('{1, 1, 16'h0080, 0,  1, 16'h0008, NOP,      16'h000A, 1});
    vecs.push_back('{1, 0, 16'h0000, 0,  1, 16'h0008, NOP,      16'h000A, 0});
    vecs.push_back('{1, 0, 16'h0000, 0,  1, 16'h0008, NOP,      16'h000A, 0});
    vecs.push_back('{1, 0, 16'h0000, 1,  1, 16'h0008, NOP,      16'h000A, 0});
    vecs.push_back('{1, 0, 16'h0000, 1,  1, 16'h0080, 16'hA525, 16'h0082, 0});
    // Branch to 0010, then at 0010 branch to 0040 (zero-wait)
    vecs.push_back('{1, 1, 16'h0010, 1,  1, 16'h0082, NOP,      16'h0084, 1});
    vecs.push_back('{1, 1, 16'h0040, 1,  1, 16'h0010, NOP,      16'h0012, 1});
    vecs.push_back('{1, 0, 16'h0000, 1,  1, 16'h0040, 16'hA5E5, 16'h0042, 0});
    // Branch out of HOLD beats the stall and the held word
    vecs.push_back('{0, 0, 16'h0000, 1,  1, 16'h0042, 16'hA5E7, 16'h0044, 0});
    vecs.push_back('{0, 1, 16'h0100, 1,  0, 16'h0000, NOP,      16'h0044, 1});
    vecs.push_back('{1, 0, 16'h0000, 1,  1, 16'h0100, 16'hA4A5, 16'h0102, 0});
    // Second branch while draining overwrites redirect target
    vecs.push_back('{1, 1, 16'h0200, 0,  1, 16'h0102, NOP,      16'h0104, 1});
    vecs.push_back('{1, 1, 16'h0300, 0,  1, 16'h0102, NOP,      16'h0104, 1});
    vecs.push_back('{1, 0, 16'h0000, 1,  1, 16'h0102, NOP,      16'h0104, 0});
    vecs.push_back('{1, 0, 16'h0000, 1,  1, 16'h0300, 16'hA6A5, 16'h0302, 0});
    // Branch coinciding with ready in DRAIN takes the new target
    vecs.push_back('{1, 1, 16'h0500, 0,  1, 16'h0302, NOP,      16'h0304, 1});
    vecs.push_back('{1, 1, 16'h0600, 1,  1, 16'h0302, NOP,      16'h0304, 1});
    vecs.push_back('{1, 0, 16'h0000, 1,  1, 16'h0600, 16'hA3A5, 16'h0602, 0});
    // PC wrap at FFFE
    vecs.push_back('{1, 1, 16'hFFFE, 1,  1, 16'h0602, NOP,      16'h0604, 1});
    vecs.push_back('{1, 0, 16'h0000, 1,  1, 16'hFFFE, 16'h5A5B, 16'h0000, 0});
    vecs.push_back('{1, 0, 16'h0000, 1,  1, 16'h0000, 16'hA5A5, 16'h0002, 0});

    // ---- Reset state, with noisy inputs that must be ignored ----
    reset = 1'b0;
    drive(1, 1, 16'h1234, 1);
    #12;
    check_outs("reset", 1'b0, 16'h0000, NOP, 16'h0002, 1'b0);

    @(negedge clk);
    reset = 1'b1;
    drive(1, 0, 16'h0000, 1);

    // ---- Table-driven vectors, one per cycle ----
    for (int i = 0; i < vecs.size(); i++) begin
      if (i != 0) @(negedge clk);
      drive(vecs[i].pw, vecs[i].bt, vecs[i].tgt, vecs[i].rdy);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                 vecs[i].e_inst, vecs[i].e_pp2, vecs[i].e_flush);
    end

    // ---- Reset asserted in DRAIN with a redirect pending (PC=0002) ----
    @(negedge clk);
    drive(1, 1, 16'h0900, 0);                   // enter DRAIN toward 0900
    #1;
    check("drain_entry.flush", 16'(flush), 16'h0001);
    @(negedge clk);
    drive(1, 0, 16'h0000, 0);
    #1;
    check("drain.req", 16'(imem_req), 16'h0001);
    check("drain.addr", imem_addr, 16'h0002);
    reset = 1'b0;                               // mid-cycle, asynchronous
    #1;
    check("rst_async.req", 16'(imem_req), 16'h0000);
    check("rst_async.pp2", PC_Plus2, 16'h0002);
    check("rst_async.inst", inst, NOP);
    @(negedge clk);
    reset = 1'b1;
    drive(1, 0, 16'h0000, 1);
    #1;
    check_outs("post_rst0", 1'b1, 16'h0000, 16'hA5A5, 16'h0002, 1'b0);
    @(negedge clk);
    #1;
    check_outs("post_rst1", 1'b1, 16'h0002, 16'hA5A7, 16'h0004, 1'b0);

    // ---- Wait state with stall in FETCH: PC holds, no capture yet ----
    @(negedge clk);
    drive(0, 0, 16'h0000, 0);
    #1;
    check_outs("ws_stall", 1'b1, 16'h0004, NOP, 16'h0006, 1'b0);
    @(negedge clk);
    drive(1, 0, 16'h0000, 1);
    #1;
    check_outs("ws_done", 1'b1, 16'h0004, 16'hA5A1, 16'h0006, 1'b0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage: the writer side of the IF/ID pipeline register.
- Owns the 16-bit PC and drives a single-outstanding-request instruction-memory handshake.
- Presents inst and PC_Plus2 to IF/ID.
- Handles stalls (PCWrite) and taken-branch redirects, and raises flush to IF/ID when a redirect occurs.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INST, 16'h0000, instruction word presented when no valid instruction is available (pipeline bubble).

Ports:
- clk  input  1  pipeline clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- PCWrite  input  1  1 = IF/ID will accept this cycle; 0 = stall, hold fetched instruction.
- branch_taken  input  1  redirect request from EX/ID; single-cycle pulse.
- branch_target  input  16  redirect address, valid with branch_taken.
- imem_req  output  1  instruction memory request.
- imem_addr  output  16  request address; stable while imem_req=1 and imem_ready=0.
- imem_rdata  input  16  instruction word, valid when imem_ready=1.
- imem_ready  input  1  completes the current request this cycle.
- inst  output  16  instruction to IF/ID.
- PC_Plus2  output  16  address of delivered instruction + 2, to IF/ID.
- flush  output  1  clears IF/ID this cycle.

Behaviour:
- State register: 2 bits.
  - FETCH: request at PC.
  - HOLD: instruction captured, waiting for PCWrite.
  - DRAIN: redirect pending behind an in-flight request.
- Reset (reset=0, async):
  - PC=RESET_PC, state=FETCH, hold_inst=NOP_INST, redirect_pc=0.
  - Outputs: imem_req=0, inst=NOP_INST, PC_Plus2=RESET_PC+2, flush=0.
- Reset deasserted:
  - imem_req=1 in FETCH and DRAIN, 0 in HOLD.
  - imem_addr=PC in FETCH; latched old address in DRAIN.
- FETCH, imem_ready=1:
  - PCWrite=1: inst=imem_rdata (combinational pass-through), PC_Plus2=PC+2, PC<=PC+2, stay FETCH. Zero-wait memory gives 1 instruction/cycle.
  - PCWrite=0: hold_inst<=imem_rdata, go HOLD, PC unchanged.
- FETCH, imem_ready=0: inst=NOP_INST, PC_Plus2=PC+2, PC held.
- HOLD:
  - inst=hold_inst, PC_Plus2=PC+2.
  - On PCWrite=1: PC<=PC+2, go FETCH.
- Redirect (branch_taken=1) has priority over stall and over data delivery:
  - flush=branch_taken, combinational in the same cycle.
  - inst forced to NOP_INST that cycle.
  - From FETCH with imem_ready=1, or from HOLD: PC<=branch_target, go FETCH, fetched or held word discarded.
  - From FETCH with imem_ready=0: redirect_pc<=branch_target, go DRAIN. Address must not change mid-request.
  - In DRAIN, a new branch_taken overwrites redirect_pc.
- DRAIN:
  - inst=NOP_INST, keep old request.
  - On imem_ready=1: discard data, PC<=redirect_pc, go FETCH.
  - branch_taken and imem_ready together: PC<=branch_target.
- PC arithmetic: 16-bit modulo. 16'hFFFE+2 wraps to 16'h0000. PC_Plus2 wraps the same way.
- Reset mid-request: request abandoned. The memory model must tolerate imem_req dropping.
- One outstanding request at most; no speculative prefetch.

Decomposition:
- Shared package holds:
  - state encoding: FETCH=2'd0, HOLD=2'd1, DRAIN=2'd2.
  - NOP encoding.
  - PC width (16) and instruction width (16), common with the IF/ID register and the hazard unit.
- No sub-module needed.
- The PC incrementer is an inline adder, shared by the PC_Plus2 output and the PC next-state logic.

Test Plan:
- Reset release, imem_ready tied 1, PCWrite=1, memory returns addr^16'hA5A5 -> inst sequence A5A5, A5A7, A5A1... one per cycle; PC_Plus2 = 2, 4, 6, ...; flush=0.
- PCWrite=0 for 3 cycles while imem_ready=1 at PC=16'h0004 -> state HOLD, imem_req=0, inst stays the word for 0004, PC_Plus2=0006 held; PCWrite=1 resumes at 0006 with no lost or duplicated instruction.
- branch_taken with target 16'h0040 at PC=16'h0010, imem_ready=1 -> flush=1 and inst=NOP that cycle; next imem_addr=0040; PC_Plus2=0042 on delivery.
- imem_ready=0 for 4 cycles at PC=0008, branch_taken to 0080 in cycle 2 -> imem_addr stays 0008 until ready; data discarded (inst=NOP); next request is 0080.
- PC=16'hFFFE, zero-wait -> delivered PC_Plus2=0000, next imem_addr=0000.
- Assert reset in DRAIN with redirect pending -> imem_req=0 immediately; after release imem_addr=RESET_PC, redirect_pc ignored.
